player_anim_sequencer: RTL
==========================

// Module: player_anim_sequencer
// PURPOSE
//  Sequences the player sprite animation. Tracks player action (idle/run/jump/dead)
//  and produces the animationOffset word consumed by playerSprites, which then
//  adds its own direction offset. Offset changes only at a frame boundary
//  (frame_tick rising edge), so a displayed frame never mixes two sprite frames.
// PARAMETERS
//  FRAME_SIZE   1080   words per sprite frame (24x45)
//  IDLE_BASE    0      word offset of idle frame (single frame)
//  RUN_BASE     1080   word offset of run frame 0
//  RUN_FRAMES   6      run frames, looping
//  JUMP_BASE    7560   word offset of jump frame 0
//  JUMP_FRAMES  4      jump frames, last frame held
//  DEAD_BASE    11880  word offset of death frame 0
//  DEAD_FRAMES  3      death frames, last frame held
//  HOLD_TICKS   4      frame boundaries each animation frame is shown (>=1)
// PORTS
//  frame_Clk        in   1   clock
//  Reset            in   1   synchronous, active-high
//  frame_tick       in   1   level, high during vertical blank
//  move_req         in   1   horizontal movement key held
//  jump_req         in   1   jump key held
//  grounded         in   1   player feet on a platform
//  hit              in   1   player struck by enemy/bullet
//  animationOffset  out  32  registered word offset of current sprite frame
//  anim_state       out  2   0 IDLE, 1 RUN, 2 JUMP, 3 DEAD
//  dead_done        out  1   death animation reached its last frame
// BEHAVIOUR
//  - Reset (sync, frame_Clk): state IDLE, frame index 0, hold count 0,
//    animationOffset=IDLE_BASE, anim_state=0, dead_done=0, tick_q=1 (no spurious
//    edge if Reset releases while frame_tick high). Reset wins over all inputs.
//  - tick_q <= frame_tick every cycle; edge = frame_tick & ~tick_q. All state,
//    index, hold and output registers update only on cycles with edge=1; outputs
//    are valid right after that clock edge (latency 1 clk from first high sample).
//  - Next state on edge, priority order:
//    DEAD: stay (terminal until Reset; all inputs ignored).
//    hit=1 (any non-DEAD state) -> DEAD.
//    IDLE/RUN with jump_req & grounded -> JUMP.
//    JUMP: -> RUN if grounded & move_req; -> IDLE if grounded & !move_req; else stay.
//      grounded is not evaluated on the entry edge (min one boundary in JUMP).
//    IDLE & move_req -> RUN; RUN & !move_req -> IDLE; else stay.
//  - On state change: index=0, hold=0. Otherwise hold increments per edge; when
//    hold==HOLD_TICKS-1 it clears and index advances: RUN wraps RUN_FRAMES-1->0;
//    JUMP/DEAD saturate at N-1; IDLE stays 0.
//  - animationOffset = BASE(next state) + next index*FRAME_SIZE, 32-bit unsigned,
//    computed from next-state values and registered on the edge.
//  - dead_done registered: 1 when state DEAD and index==DEAD_FRAMES-1; stays 1.
//  - anim_state registered alongside animationOffset (always consistent).
//  - No edge cycles: every register holds, regardless of input changes.
// TESTING
//  1 Reset 3 clks, inputs 0, tick toggling -> offset 0, state 0, dead_done 0.
//  2 move_req=1 held, grounded=1: edge1 -> state 1, offset 1080; edge5 -> 2160;
//    edge21 -> 6480; edge25 -> 1080 (wrap); drop move_req next edge -> 0, state 0.
//  3 IDLE, jump_req=1 grounded=1 edge -> state 2, 7560; grounded=0 for 20 edges ->
//    advances every 4 edges, holds 10800; grounded=1, move_req=1 -> state 1, 1080.
//  4 RUN, hit=1 & jump_req=1 same edge -> state 3, 11880; edge+8 -> 14040,
//    dead_done=1; 10 more edges with move_req/jump_req -> unchanged.
//  5 frame_tick held high 50 clks -> exactly one update; Reset released with
//    frame_tick high -> no update until tick falls and rises again.
//  6 Reset asserted mid-RUN (offset 3240) without edge -> next clk offset 0, state 0.

Source files
------------

// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer: tracks player action and produces the sprite frame word offset,
// updating only on frame_tick rising edges so a displayed frame never mixes sprites.
module player_anim_sequencer #(
    parameter int FRAME_SIZE  = 1080,
    parameter int IDLE_BASE   = 0,
    parameter int RUN_BASE    = 1080,
    parameter int RUN_FRAMES  = 6,
    parameter int JUMP_BASE   = 7560,
    parameter int JUMP_FRAMES = 4,
    parameter int DEAD_BASE   = 11880,
    parameter int DEAD_FRAMES = 3,
    parameter int HOLD_TICKS  = 4
) (
    input  logic        frame_Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        move_req,
    input  logic        jump_req,
    input  logic        grounded,
    input  logic        hit,
    output logic [31:0] animationOffset,
    output logic [1:0]  anim_state,
    output logic        dead_done
);
    typedef enum logic [1:0] {IDLE, RUN, JUMP, DEAD} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] RUN_LAST  = 8'(RUN_FRAMES - 1);
    localparam logic [7:0] JUMP_LAST = 8'(JUMP_FRAMES - 1);
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_FRAMES - 1);

    state_t      state, nextState;
    logic [7:0]  frameIdx, nextIdx, holdCnt, nextHold;
    logic [31:0] baseOffset;
    logic        tickQ, tickEdge, stateChange, holdWrap;

    assign tickEdge = frame_tick & ~tickQ;

    // IDLE/RUN share one rule: move_req alone selects between them
    always_comb begin
        nextState = state;
        if (state != DEAD) begin
            if (hit)
                nextState = DEAD;
            else if (state == JUMP)
                nextState = grounded ? (move_req ? RUN : IDLE) : JUMP;
            else if (jump_req && grounded)
                nextState = JUMP;
            else
                nextState = move_req ? RUN : IDLE;
        end
    end

    assign stateChange = nextState != state;
    assign holdWrap    = holdCnt == HOLD_LAST;
    assign nextHold    = (stateChange || holdWrap) ? 8'd0 : holdCnt + 8'd1;

    always_comb begin
        nextIdx = frameIdx;
        if (stateChange)
            nextIdx = 8'd0;
        else if (holdWrap)
            nextIdx = (state == RUN)  ? ((frameIdx == RUN_LAST) ? 8'd0 : frameIdx + 8'd1) :
                      (state == JUMP) ? ((frameIdx == JUMP_LAST) ? frameIdx : frameIdx + 8'd1) :
                      (state == DEAD) ? ((frameIdx == DEAD_LAST) ? frameIdx : frameIdx + 8'd1) :
                      8'd0;
    end

    assign baseOffset = (nextState == RUN)  ? 32'(RUN_BASE)  :
                        (nextState == JUMP) ? 32'(JUMP_BASE) :
                        (nextState == DEAD) ? 32'(DEAD_BASE) : 32'(IDLE_BASE);

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            tickQ           <= 1'b1;
            state           <= IDLE;
            frameIdx        <= 8'd0;
            holdCnt         <= 8'd0;
            animationOffset <= 32'(IDLE_BASE);
            anim_state      <= 2'd0;
            dead_done       <= 1'b0;
        end else begin
            tickQ <= frame_tick;
            if (tickEdge) begin
                state           <= nextState;
                frameIdx        <= nextIdx;
                holdCnt         <= nextHold;
                animationOffset <= baseOffset + 32'(nextIdx) * 32'(FRAME_SIZE);
                anim_state      <= nextState;
                dead_done       <= (nextState == DEAD) && (nextIdx == DEAD_LAST);
            end
        end
    end
endmodule
